// File: rtl/rcp_iter.sv
// rcp_iter: iterative Newton-Raphson reciprocal, r_o ~= floor(2^WIDTH / a_i).
// One operand in flight at a time; valid/ready handshake on both sides.
// Optional feature macro RCP_ITER_DZ_EN: when defined, a zero divisor skips
// the iterations, returns all ones and raises dz_o. When undefined, zero is
// treated like one and dz_o is tied low.
`timescale 1ns/1ps

module rcp_iter #(
  parameter int WIDTH = 16,
  parameter int ITERS = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] a_i,
  output logic             in_rdy_o,
  output logic             v_o,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] r_o,
  output logic             dz_o
);

  // Estimate is an integer approximation of 2^WIDTH/a, needs one extra bit for a=1.
  localparam int EW = WIDTH + 1;
  // Product width with headroom so no refinement product ever wraps.
  localparam int PW = 2 * WIDTH + 4;
  localparam int CW = 4;

  localparam logic [EW-1:0]    ONE_E    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    TWO_P    = {{(PW-WIDTH-2){1'b0}}, 1'b1, {(WIDTH+1){1'b0}}};
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    LAST_CNT = CW'(ITERS > 1 ? ITERS - 2 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [EW-1:0]    est_q, est_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] a_eff;
  logic [EW-1:0]    s_full, seed, est_in, est_new;
  logic             nxt, pow2;
  logic [PW-1:0]    prod_p, corr, prod_n;
  logic [WIDTH-1:0] r_new;
  logic             unused_bits;

  // A zero divisor runs through the datapath as one (result saturates to all ones).
  assign a_eff = (a_q == '0) ? ONE_W : a_q;

  // Seed: 2^(WIDTH-L) from the leading one, trimmed by the next bit down so the
  // starting relative error stays within 1/4; powers of two start exact.
  always_comb begin
    s_full = ONE_E << WIDTH;
    nxt    = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (a_eff[i]) begin
        s_full = ONE_E << (WIDTH - i);
        nxt    = a_eff[i-1];
      end
    end
    pow2 = ((a_eff & (a_eff - ONE_W)) == '0);
    if (pow2)
      seed = s_full;
    else if (nxt)
      seed = s_full >> 1;
    else
      seed = (s_full >> 1) + (s_full >> 2);
  end

  // One refinement: est' = est * (2^(W+1) - a*est) / 2^W, saturated to WIDTH bits.
  always_comb begin
    est_in  = (state_q == S_SEED) ? seed : est_q;
    prod_p  = {{(PW-WIDTH){1'b0}}, a_eff} * {{(PW-EW){1'b0}}, est_in};
    corr    = (prod_p >= TWO_P) ? '0 : (TWO_P - prod_p);
    prod_n  = {{(PW-EW){1'b0}}, est_in} * corr;
    est_new = prod_n[WIDTH +: EW];
    r_new   = est_new[WIDTH] ? '1 : est_new[WIDTH-1:0];
  end

  assign unused_bits = ^{prod_n[PW-1:WIDTH+EW], prod_n[WIDTH-1:0]};

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    est_d   = est_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (v_i) begin
          a_d     = a_i;
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        cnt_d = '0;
        est_d = est_new;
`ifdef RCP_ITER_DZ_EN
        if (a_q == '0) begin
          r_d     = '1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else
`endif
        if (ITERS == 1) begin
          r_d     = r_new;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        est_d = est_new;
        if (cnt_q == LAST_CNT) begin
          r_d     = r_new;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (rdy_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      est_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign in_rdy_o = (state_q == S_IDLE);
  assign v_o      = (state_q == S_DONE);
  assign r_o      = r_q;

`ifdef RCP_ITER_DZ_EN
  assign dz_o = dz_q;
`else
  logic unused_dz;
  assign unused_dz = dz_q;
  assign dz_o      = 1'b0;
`endif

endmodule

// File: tb/tb_rcp_iter.sv
// Self-checking bench for rcp_iter (WIDTH=16, ITERS=3) against an arithmetic
// reference: floor(65536/a) saturated, with +/-1 tolerance and exact powers of two.
`timescale 1ns/1ps

module tb_rcp_iter;
  localparam int WIDTH = 16;
  localparam int ITERS = 3;
`ifdef RCP_ITER_DZ_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        v_i = 1'b0;
  logic [15:0] a_i = '0;
  logic        in_rdy_o;
  logic        v_o;
  logic        rdy_i = 1'b0;
  logic [15:0] r_o;
  logic        dz_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rcp_iter #(.WIDTH(WIDTH), .ITERS(ITERS)) dut (
    .clk_i(clk), .rst_i(rst_i), .v_i(v_i), .a_i(a_i), .in_rdy_o(in_rdy_o),
    .v_o(v_o), .rdy_i(rdy_i), .r_o(r_o), .dz_o(dz_o)
  );

  function automatic int exp_rcp(input int a);
    int q;
    if (a == 0) return 65535;
    q = 65536 / a;
    return (q > 65535) ? 65535 : q;
  endfunction

  function automatic int exp_lat(input int a);
    return (a == 0 && DZ_EN) ? 2 : ITERS + 1;
  endfunction

  function automatic bit is_pow2(input int a);
    return (a != 0) && ((a & (a - 1)) == 0);
  endfunction

  // Accept one operand (rdy_i held low); lat counts edges from the accept edge
  // (inclusive) until v_o is seen high, bounded at 30.
  task automatic do_op(input logic [15:0] a, output int lat);
    @(negedge clk);
    v_i = 1'b1; a_i = a;
    @(posedge clk); #1;
    v_i = 1'b0; a_i = 16'($urandom);
    lat = 1;
    while (v_o !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk); rdy_i = 1'b1;
    @(posedge clk); #1; rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; v_i = 1'b1; rdy_i = 1'b1; a_i = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_rdy_o !== 1'b1) $display("FAIL reset_in_rdy got=%b want=1", in_rdy_o); else n_pass++;
    n_checks++; if (v_o !== 1'b0) $display("FAIL reset_v_o got=%b want=0", v_o); else n_pass++;
    n_checks++; if (r_o !== 16'h0000) $display("FAIL reset_r_o got=%h want=0000", r_o); else n_pass++;
    n_checks++; if (dz_o !== 1'b0) $display("FAIL reset_dz_o got=%b want=0", dz_o); else n_pass++;
    @(negedge clk);
    rst_i = 1'b0; v_i = 1'b0; rdy_i = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    do_op(16'd2, lat);
    $display("op a=0x0002 r=0x%h dz=%b lat=%0d", r_o, dz_o, lat);
    n_checks++; if (lat != exp_lat(2)) $display("FAIL basic_latency got=%0d want=%0d", lat, exp_lat(2)); else n_pass++;
    n_checks++; if (r_o !== 16'h8000) $display("FAIL basic_r_o got=%h want=8000", r_o); else n_pass++;
    n_checks++; if (dz_o !== 1'b0) $display("FAIL basic_dz_o got=%b want=0", dz_o); else n_pass++;
    release_result();
    n_checks++; if (v_o !== 1'b0) $display("FAIL basic_v_o_drop got=%b want=0", v_o); else n_pass++;
  endtask

  task automatic test_corners();
    int list [10] = '{3, 32768, 1, 4, 256, 16384, 65535, 5, 32769, 49152};
    int lat, e, r;
    foreach (list[k]) begin
      do_op(16'(list[k]), lat);
      e = exp_rcp(list[k]);
      r = int'(r_o);
      $display("op a=0x%h r=0x%h dz=%b lat=%0d", 16'(list[k]), r_o, dz_o, lat);
      n_checks++; if (lat != exp_lat(list[k])) $display("FAIL corner_latency a=%0d got=%0d want=%0d", list[k], lat, exp_lat(list[k])); else n_pass++;
      if (is_pow2(list[k])) begin
        n_checks++; if (r != e) $display("FAIL corner_exact a=%0d got=%0d want=%0d", list[k], r, e); else n_pass++;
      end else begin
        n_checks++; if (r < e - 1 || r > e + 1) $display("FAIL corner_range a=%0d got=%0d want=%0d+/-1", list[k], r, e); else n_pass++;
      end
      n_checks++; if (dz_o !== 1'b0) $display("FAIL corner_dz a=%0d got=%b want=0", list[k], dz_o); else n_pass++;
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat, highs;
    do_op(16'h0100, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      v_i = (c == 2); a_i = 16'd7;
      #1;
      n_checks++; if (v_o !== 1'b1 || in_rdy_o !== 1'b0 || r_o !== 16'h0100)
        $display("FAIL hold_cycle%0d got v=%b rdy=%b r=%h want v=1 rdy=0 r=0100", c, v_o, in_rdy_o, r_o);
      else n_pass++;
    end
    @(negedge clk);
    v_i = 1'b0; rdy_i = 1'b1;
    @(posedge clk); #1;
    rdy_i = 1'b0;
    n_checks++; if (v_o !== 1'b0 || in_rdy_o !== 1'b1) $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", v_o, in_rdy_o); else n_pass++;
    highs = 0;
    repeat (8) begin @(negedge clk); if (v_o === 1'b1) highs++; end
    n_checks++; if (highs != 0) $display("FAIL hold_ignored_op got=%0d want=0 result cycles", highs); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, highs;
    do_op(16'd5, lat);
    release_result();
    @(negedge clk); v_i = 1'b1; a_i = 16'd9;
    @(posedge clk); #1; v_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_rdy_o !== 1'b1 || v_o !== 1'b0 || r_o !== 16'h0000)
      $display("FAIL midreset got rdy=%b v=%b r=%h want rdy=1 v=0 r=0000", in_rdy_o, v_o, r_o);
    else n_pass++;
    @(negedge clk); rst_i = 1'b0; rdy_i = 1'b1;
    highs = 0;
    repeat (10) begin @(negedge clk); if (v_o === 1'b1) highs++; end
    rdy_i = 1'b0;
    n_checks++; if (highs != 0) $display("FAIL midreset_stale got=%0d want=0 result cycles", highs); else n_pass++;
  endtask

  task automatic test_zero();
    int lat;
    do_op(16'd0, lat);
    $display("op a=0x0000 r=0x%h dz=%b lat=%0d", r_o, dz_o, lat);
    n_checks++; if (lat != exp_lat(0)) $display("FAIL zero_latency got=%0d want=%0d", lat, exp_lat(0)); else n_pass++;
    n_checks++; if (r_o !== 16'hFFFF) $display("FAIL zero_r_o got=%h want=ffff", r_o); else n_pass++;
    n_checks++; if (dz_o !== DZ_EN) $display("FAIL zero_dz got=%b want=%b", dz_o, DZ_EN); else n_pass++;
    release_result();
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int sent = 0, got = 0, cyc = 0, a, e, r;
    const int N = 120;
    logic [15:0] next_a;
    next_a = 16'($urandom_range(1, 65535));
    while (got < N && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      v_i   = (sent < N);
      a_i   = next_a;
      rdy_i = ($urandom_range(0, 3) != 0);
      #1;
      if (v_i && in_rdy_o) begin
        exp_q.push_back(int'(a_i));
        sent++;
        next_a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 64)) : 16'($urandom_range(1, 65535));
      end
      if (v_o && rdy_i) begin
        r = int'(r_o);
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra_result got r=%0d want no result", r);
        end else begin
          a = exp_q.pop_front();
          e = exp_rcp(a);
          $display("op a=0x%h r=0x%h dz=%b", 16'(a), r_o, dz_o);
          if (r < e - 1 || r > e + 1 || dz_o !== 1'b0)
            $display("FAIL b2b_result a=%0d got r=%0d dz=%b want r=%0d+/-1 dz=0", a, r, dz_o, e);
          else n_pass++;
        end
        got++;
      end
    end
    @(negedge clk); v_i = 1'b0; rdy_i = 1'b0;
    n_checks++; if (got != N || exp_q.size() != 0) $display("FAIL b2b_count got=%0d pending=%0d want=%0d pending=0", got, exp_q.size(), N); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_zero();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
